// File: rtl/fp32_pkg.sv
// Shared binary32 helpers: field slicing, flush-to-zero unpack, common constants.
// Reused by the FP32 multiplier, this divider and future adders.
package fp32_pkg;

  localparam int          FP_BIAS      = 127;
  localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;
  localparam logic [31:0] FP_QNAN_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
  } fp32_unpacked_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } div_state_t;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fp_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

  // Denormals flush to zero: a zero exponent yields a zero significand.
  function automatic fp32_unpacked_t fp_unpack(input logic [31:0] x);
    fp32_unpacked_t u;
    u.sign = fp_sign(x);
    u.exp  = fp_exp(x);
    u.sig  = (fp_exp(x) == 8'd0) ? 24'd0 : {1'b1, fp_frac(x)};
    return u;
  endfunction

endpackage

// File: rtl/fp_div_round.sv
// Normalises the raw 26-bit quotient, rounds to nearest-even and
// applies overflow/underflow saturation to form the binary32 quotient.
module fp_div_round
  import fp32_pkg::*;
(
  input  logic [25:0] q,
  input  logic [25:0] rem,
  input  logic [7:0]  ea,
  input  logic [7:0]  eb,
  input  logic        sign,
  output logic [31:0] result
);

  logic              w_norm;
  logic              w_guard;
  logic              w_sticky;
  logic              w_round_up;
  logic              w_carry;
  logic [22:0]       w_mant;
  logic [22:0]       w_mant_rnd;
  logic signed [9:0] w_exp;

  // Normalise, round to nearest-even, then saturate the exponent range.
  always_comb begin
    w_norm = q[25];
    if (w_norm) begin
      w_mant   = q[24:2];
      w_guard  = q[1];
      w_sticky = q[0] | (rem != 26'd0);
    end else begin
      w_mant   = q[23:1];
      w_guard  = q[0];
      w_sticky = (rem != 26'd0);
    end
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    // An all-ones mantissa wraps to zero here; the carry bumps the exponent.
    {w_carry, w_mant_rnd} = {1'b0, w_mant} + {23'd0, w_round_up};
    w_exp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(FP_BIAS))
          - (w_norm ? 10'sd0 : 10'sd1) + (w_carry ? 10'sd1 : 10'sd0);
    if (w_exp >= 10'sd255) begin
      result = {sign, FP_EXP_MAX, 23'd0};
    end else if (w_exp <= 10'sd0) begin
      result = {sign, 31'd0};
    end else begin
      result = {sign, w_exp[7:0], w_mant_rnd};
    end
  end

endmodule

// File: rtl/fldiv_seq.sv
// Iterative restoring binary32 divider with valid/ready handshakes;
// retires BITS_PER_CYCLE quotient bits per DIV cycle.
module fldiv_seq
  import fp32_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam int N_IT = 26 / BITS_PER_CYCLE;
  localparam int CW   = $clog2(N_IT);

  div_state_t     r_state;
  logic [CW-1:0]  r_cnt;
  logic [25:0]    r_q;
  logic [25:0]    r_rem;
  logic [23:0]    r_mb;
  logic [7:0]     r_ea;
  logic [7:0]     r_eb;
  logic           r_sign;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [31:0]    r_result;

  fp32_unpacked_t w_a;
  fp32_unpacked_t w_b;
  logic           w_sign;
  logic           w_special;
  logic [31:0]    w_special_res;
  logic [25:0]    w_rem_nxt;
  logic [25:0]    w_q_nxt;
  logic [31:0]    w_round_res;

  assign w_a    = fp_unpack(a_operand);
  assign w_b    = fp_unpack(b_operand);
  assign w_sign = w_a.sign ^ w_b.sign;

  // Special-case detection in priority order; these bypass the iteration.
  always_comb begin
    w_special     = 1'b1;
    w_special_res = FP_QNAN_ZERO;
    if ((w_a.exp == FP_EXP_MAX) || (w_b.exp == FP_EXP_MAX)) begin
      w_special_res = FP_QNAN_ZERO;
    end else if ((w_a.exp == 8'd0) && (w_b.exp == 8'd0)) begin
      w_special_res = FP_QNAN_ZERO;
    end else if (w_b.exp == 8'd0) begin
      w_special_res = {w_sign, FP_EXP_MAX, 23'd0};
    end else if (w_a.exp == 8'd0) begin
      w_special_res = {w_sign, 31'd0};
    end else begin
      w_special     = 1'b0;
      w_special_res = FP_QNAN_ZERO;
    end
  end

  // Restoring steps; r_rem holds the next remainder to compare (pre-shifted).
  always_comb begin
    w_rem_nxt = r_rem;
    w_q_nxt   = r_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (w_rem_nxt >= {2'b00, r_mb}) begin
        w_rem_nxt = (w_rem_nxt - {2'b00, r_mb}) << 1;
        w_q_nxt   = {w_q_nxt[24:0], 1'b1};
      end else begin
        w_rem_nxt = w_rem_nxt << 1;
        w_q_nxt   = {w_q_nxt[24:0], 1'b0};
      end
    end
  end

  fp_div_round u_round (
    .q      (r_q),
    .rem    (r_rem),
    .ea     (r_ea),
    .eb     (r_eb),
    .sign   (r_sign),
    .result (w_round_res)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_mb        <= '0;
      r_ea        <= '0;
      r_eb        <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_ea       <= w_a.exp;
            r_eb       <= w_b.exp;
            r_sign     <= w_sign;
            r_mb       <= w_b.sig;
            r_rem      <= {2'b00, w_a.sig};
            r_q        <= '0;
            r_cnt      <= CW'(N_IT - 1);
            r_in_ready <= 1'b0;
            if (w_special) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_DIV;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          if (r_cnt == '0) begin
            r_state <= ST_ROUND;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_ROUND: begin
          r_result    <= w_round_res;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_fldiv_seq.sv
// Directed bench for fldiv_seq: instance 0 uses 1 bit/cycle, instance 1
// uses 2 bits/cycle; expected values are hand-computed constants.
module tb_fldiv_seq;

  logic        clk;
  logic [1:0]  rst;
  logic [1:0]  in_valid;
  logic [1:0]  out_ready;
  logic [31:0] a_op [2];
  logic [31:0] b_op [2];
  wire  [1:0]  in_ready;
  wire  [1:0]  out_valid;
  wire  [31:0] res0;
  wire  [31:0] res1;

  int errors = 0;
  int checks = 0;

  fldiv_seq #(.BITS_PER_CYCLE(1)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_operand(a_op[0]), .b_operand(b_op[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .result(res0)
  );

  fldiv_seq #(.BITS_PER_CYCLE(2)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_operand(a_op[1]), .b_operand(b_op[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .result(res1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] res_of(input int sel);
    return (sel == 0) ? res0 : res1;
  endfunction

  // Issues one operation and measures cycles from the accept edge to out_valid.
  task automatic issue_and_wait(input int sel, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output bit leak);
    int waited;
    waited = 0;
    lat = -1;
    leak = 1'b0;
    @(negedge clk);
    while (!in_ready[sel] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready[sel]) begin
      a_op[sel] = a;
      b_op[sel] = b;
      in_valid[sel] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[sel] = 1'b0;
      a_op[sel] = 32'hDEAD_BEEF;
      b_op[sel] = 32'h1234_5678;
      lat = 1;
      while (!out_valid[sel] && lat < 100) begin
        if (in_ready[sel]) leak = 1'b1;
        @(posedge clk);
        #1;
        lat++;
      end
      if (!out_valid[sel]) lat = -1;
    end
  endtask

  task automatic test_reset;
    rst = 2'b11;
    in_valid = 2'b00;
    out_ready = 2'b00;
    for (int s = 0; s < 2; s++) begin
      a_op[s] = 32'h0;
      b_op[s] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (in_ready[s] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", s, in_ready[s]);
      end
      checks++;
      if (out_valid[s] !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", s, out_valid[s]);
      end
      checks++;
      if (res_of(s) !== 32'h0) begin
        errors++; $display("FAIL reset_result[%0d]: got %h want 00000000", s, res_of(s));
      end
    end
    @(negedge clk);
    rst = 2'b00;
  endtask

  task automatic test_div_timing(input int sel, input int exp_lat);
    int lat;
    bit leak;
    out_ready[sel] = 1'b1;
    issue_and_wait(sel, 32'h40C0_0000, 32'h4000_0000, lat, leak);
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL div_latency[%0d]: got %0d want %0d", sel, lat, exp_lat);
    end
    checks++;
    if (leak || in_ready[sel] !== 1'b0) begin
      errors++; $display("FAIL div_in_ready_low[%0d]: got leak=%b now=%b want 0", sel, leak, in_ready[sel]);
    end
    checks++;
    if (res_of(sel) !== 32'h4040_0000) begin
      errors++; $display("FAIL div_6_2[%0d]: got %h want 40400000", sel, res_of(sel));
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid[sel] !== 1'b0 || in_ready[sel] !== 1'b1) begin
      errors++; $display("FAIL div_release[%0d]: got valid=%b ready=%b want 0/1", sel, out_valid[sel], in_ready[sel]);
    end
  endtask

  task automatic test_round(input int sel, input int exp_lat);
    int lat;
    bit leak;
    out_ready[sel] = 1'b1;
    issue_and_wait(sel, 32'h3F80_0000, 32'h4040_0000, lat, leak);
    checks++;
    if (lat != exp_lat || res_of(sel) !== 32'h3EAA_AAAB) begin
      errors++; $display("FAIL round_1_3[%0d]: got %h lat %0d want 3eaaaaab lat %0d", sel, res_of(sel), lat, exp_lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_specials;
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] ve [5];
    int          vl [5];
    int lat;
    bit leak;
    va[0] = 32'hBF80_0000; vb[0] = 32'h0000_0000; ve[0] = 32'hFF80_0000; vl[0] = 1;
    va[1] = 32'h7F80_0000; vb[1] = 32'h4000_0000; ve[1] = 32'h0000_0000; vl[1] = 1;
    va[2] = 32'h0000_0000; vb[2] = 32'h0000_0000; ve[2] = 32'h0000_0000; vl[2] = 1;
    va[3] = 32'h7F00_0000; vb[3] = 32'h0080_0000; ve[3] = 32'h7F80_0000; vl[3] = 28;
    va[4] = 32'h0080_0000; vb[4] = 32'h7F00_0000; ve[4] = 32'h0000_0000; vl[4] = 28;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue_and_wait(0, va[i], vb[i], lat, leak);
      checks++;
      if (lat != vl[i]) begin
        errors++; $display("FAIL special_lat[%0d]: got %0d want %0d", i, lat, vl[i]);
      end
      checks++;
      if (res0 !== ve[i]) begin
        errors++; $display("FAIL special_res[%0d]: got %h want %h", i, res0, ve[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    bit leak;
    out_ready[0] = 1'b0;
    issue_and_wait(0, 32'h40C0_0000, 32'h4000_0000, lat, leak);
    checks++;
    if (lat != 28 || res0 !== 32'h4040_0000) begin
      errors++; $display("FAIL bp_first: got %h lat %0d want 40400000 lat 28", res0, lat);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || res0 !== 32'h4040_0000) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b ready=%b res=%h want 1/0/40400000", k, out_valid[0], in_ready[0], res0);
      end
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_reset_mid(input int sel, input int exp_lat);
    bit pulse;
    pulse = 1'b0;
    out_ready[sel] = 1'b1;
    @(negedge clk);
    a_op[sel] = 32'h40C0_0000;
    b_op[sel] = 32'h4000_0000;
    in_valid[sel] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (out_valid[sel]) pulse = 1'b1;
      @(posedge clk);
      #1;
    end
    rst[sel] = 1'b1;
    @(posedge clk);
    #1;
    rst[sel] = 1'b0;
    checks++;
    if (in_ready[sel] !== 1'b1 || out_valid[sel] !== 1'b0 || res_of(sel) !== 32'h0) begin
      errors++; $display("FAIL midrst_state[%0d]: got ready=%b valid=%b res=%h want 1/0/0", sel, in_ready[sel], out_valid[sel], res_of(sel));
    end
    for (int k = 0; k < 40; k++) begin
      if (out_valid[sel]) pulse = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (pulse) begin
      errors++; $display("FAIL midrst_no_pulse[%0d]: got out_valid pulse want none", sel);
    end
    test_round(sel, exp_lat);
  endtask

  initial begin
    test_reset();
    test_div_timing(0, 28);
    test_round(0, 28);
    test_specials();
    test_backpressure();
    test_reset_mid(0, 28);
    test_div_timing(1, 15);
    test_round(1, 15);
    test_reset_mid(1, 15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
